// File: rtl/hilo_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle over 32 cycles.
module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        div_q, div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    logic        sgn_s;
    logic [31:0] rs_abs_s, rt_abs_s;
    logic [32:0] mul_sum_s;
    logic [32:0] rem_cand_s;
    logic        rem_ge_s;
    logic [31:0] rem_diff_s;
    logic [63:0] step_s;

    assign sgn_s    = ~op[0];
    assign rs_abs_s = (sgn_s && rs_val[31]) ? neg32(rs_val) : rs_val;
    assign rt_abs_s = (sgn_s && rt_val[31]) ? neg32(rt_val) : rt_val;

    // Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, dividend/quotient}.
    assign mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign rem_cand_s = acc_q[63:31];
    assign rem_ge_s   = (rem_cand_s >= {1'b0, opnd_q});
    assign rem_diff_s = rem_cand_s[31:0] - opnd_q;
    assign step_s     = div_q ? (rem_ge_s ? {rem_diff_s, acc_q[30:0], 1'b1}
                                          : {rem_cand_s[31:0], acc_q[30:0], 1'b0})
                              : {mul_sum_s, acc_q[31:1]};

    // Next-state, iteration and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hi_we) begin
                    hi_d = wdata;
                end else begin
                    hi_d = hi_q;
                end
                if (lo_we) begin
                    lo_d = wdata;
                end else begin
                    lo_d = lo_q;
                end
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = 5'd0;
                    div_d     = op[1];
                    neg_res_d = sgn_s & (rs_val[31] ^ rt_val[31]);
                    neg_rem_d = sgn_s & rs_val[31];
                    dz_d      = op[1] & (rt_val == 32'd0);
                    if (op[1]) begin
                        acc_d  = {32'd0, rs_abs_s};
                        opnd_d = rt_abs_s;
                    end else begin
                        acc_d  = {32'd0, rt_abs_s};
                        opnd_d = rs_abs_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = step_s;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (div_q) begin
                        // A zero divisor yields all-ones quotient regardless of operand signs.
                        lo_d = dz_q ? 32'hFFFF_FFFF
                                    : (neg_res_q ? neg32(step_s[31:0]) : step_s[31:0]);
                        hi_d = neg_rem_q ? neg32(step_s[63:32]) : step_s[63:32];
                    end else begin
                        {hi_d, lo_d} = neg_res_q ? (~step_s + 64'd1) : step_s;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench: arithmetic reference model checked every cycle, plus literal result checks.
module tb_hilo_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vecs = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    hilo_muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {hi,lo} from plain arithmetic.
    function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, m;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin
                q = sa * sb;
                r = q;
            end
            2'd1: r = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // Transaction-level model: cycles remaining, pending result, architectural HI/LO.
    int          m_rem = 0;
    logic [63:0] m_pend = 64'd0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic        m_done = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_rem = 0; m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0;
            chk_en = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_rem == 0) begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
                if (start) begin
                    m_pend = model_res(op, rs_val, rt_val);
                    m_rem = 32;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_rem != 0});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("busy_and_done", {31'd0, busy & done}, 32'd0);
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        int cyc, bcnt;
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; bcnt = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_timeout"}, {31'd0, cyc >= 40}, 32'd0);
        chk({name, "_busy_cycles"}, bcnt, 32'd32);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
    endtask

    initial begin
        int dcnt, bcnt;
        reset = 1'b1; start = 1'b0; op = 2'd0; rs_val = 32'd0; rt_val = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg");
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        run_op(2'd3, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, "divu");
        run_op(2'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, "divu_zero");
        run_op(2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero_neg");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minmin");

        // MTHI then MTLO in idle, visible the next cycle.
        @(posedge clk); #1; hi_we = 1'b1; wdata = 32'h1357_9BDF;
        @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2468_ACE0;
        chk("mthi", hi, 32'h1357_9BDF);
        @(posedge clk); #1; lo_we = 1'b0;
        chk("mtlo", lo, 32'h2468_ACE0);

        // Start and MTHI during RUN are ignored.
        @(posedge clk); #1;
        start = 1'b1; op = 2'd1; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; op = 2'd3; rs_val = 32'd1; rt_val = 32'd1; hi_we = 1'b1; wdata = 32'hAAAA_AAAA;
        @(posedge clk); #1; start = 1'b0; hi_we = 1'b0;
        bcnt = 0;
        while (!done && bcnt < 40) begin
            @(posedge clk); #1; bcnt++;
        end
        chk("ignored_hi", hi, 32'hFFFF_FFFE);
        chk("ignored_lo", lo, 32'h0000_0001);

        // Reset in the middle of an operation discards it.
        @(posedge clk); #1;
        start = 1'b1; op = 2'd1; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        dcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("midreset_no_done", dcnt, 32'd0);

        // MTLO together with start: operation result wins.
        @(posedge clk); #1;
        lo_we = 1'b1; wdata = 32'h5555_5555;
        run_op(2'd3, 32'd45, 32'd6, 32'h0000_0003, 32'h0000_0007, "mtlo_with_start");
        lo_we = 1'b0;

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative multiply/divide unit in the EX stage, fed by the ID/EX register, owning the architectural HI and LO registers. It executes MULT, MULTU, DIV and DIVU over 32 iterations, accepts MTHI/MTLO writes, and drives a busy flag to the hazard logic. Upstream holds the pipeline while busy is high. Downstream consumers (MFHI/MFLO in MEM/WB) read the hi/lo outputs.

## Interface
- No parameters. Datapath fixed at 32 bits, 32 iterations.
- clk  in  1  pipeline clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  begin operation `op` on rs_val/rt_val; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  32  multiplicand / dividend
- rt_val  in  32  multiplier / divisor
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in progress; hazard unit stalls on it
- done  out  1  one-cycle pulse: HI/LO just updated by an operation
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN. A 5-bit iteration counter runs 0..31.
- IDLE with start=1: latch operands and op, enter RUN, clear counter.
  - Signed ops (MULT, DIV) latch absolute values and record the result signs.
  - Product sign = sign(rs) XOR sign(rt). Remainder sign = sign(rs).
- RUN, multiply: shift-add, one multiplier bit per cycle, 64-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle. Quotient goes to LO, remainder to HI.
- RUN with counter=31: apply sign correction, write {HI,LO}, return to IDLE, set done for the following cycle.
- Arithmetic rules:
  - MULT/MULTU: {HI,LO} = full 64-bit product, two's complement for MULT.
  - DIV rounds toward zero. DIV -2^31 / -1 gives LO=0x80000000, HI=0.
  - Divide by zero (DIV or DIVU): normal 32-cycle latency, result LO=0xFFFFFFFF, HI=rs_val.
- start while RUN is ignored; operands are not re-latched.
- hi_we / lo_we:
  - In IDLE: write wdata at the edge.
  - In RUN: ignored.
  - In IDLE together with start: the write takes effect and is later overwritten by the completing operation.
- Reset (any state, including mid-RUN): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0. The partial result is discarded.

## Timing
- Reset values: busy=0, done=0, hi=0x00000000, lo=0x00000000.
- Cycle numbering:
  - Edge E0 samples start in IDLE.
  - busy is high from after E0 through E32.
  - Iterations run at E1..E32.
  - HI/LO are updated at E32.
  - After E32: busy=0, done=1 for exactly one cycle, new hi/lo visible.
- Latency is 32 cycles from the accepting edge to the result, independent of op and operand values.
- A new start is accepted at E32+1 at the earliest; back-to-back operations are sustainable every 33 edges.
- busy is a registered output (no combinational path from start). Upstream stalls from the cycle after issuing start.
- done and busy are never high in the same cycle.
- hi/lo are registered outputs. MTHI/MTLO data is visible the cycle after the write edge.

## Test plan
- Reset, then MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> after 32 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulses once, busy high exactly 32 cycles.
- MULT rs=0xFFFFFFFD (-3) rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100 rt=7 -> lo=0x0000000E, hi=0x00000002.
- DIVU rs=0x12345678 rt=0 -> lo=0xFFFFFFFF, hi=0x12345678.
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF, then:
  - start with new operands and hi_we=1 (wdata=0xAAAAAAAA) at cycle 5 -> both ignored; final result matches the first operation.
  - reset asserted at cycle 10 -> next cycle busy=0, done=0, hi=lo=0, and no done pulse follows.
